// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and phase encoding for the VGA timing slice.
package vga_pkg;

    localparam int COORD_W  = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = 800;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = 525;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } vga_phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a position counter with its active/front/sync/back phase tracker.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACT_LEN  = H_ACTIVE,
    parameter int FP_LEN   = H_FP,
    parameter int SYNC_LEN = H_SYNC,
    parameter int BP_LEN   = H_BP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic [COORD_W-1:0] count,
    output vga_phase_t         phase,
    output logic               tc
);

    localparam int TOTAL = ACT_LEN + FP_LEN + SYNC_LEN + BP_LEN;

    localparam logic [COORD_W-1:0] ACT_END  = COORD_W'(ACT_LEN - 1);
    localparam logic [COORD_W-1:0] FP_END   = COORD_W'(ACT_LEN + FP_LEN - 1);
    localparam logic [COORD_W-1:0] SYNC_END = COORD_W'(ACT_LEN + FP_LEN + SYNC_LEN - 1);
    localparam logic [COORD_W-1:0] LAST     = COORD_W'(TOTAL - 1);

    assign tc = (count == LAST);

    // The >= catches any out-of-range count and folds it back to 0 on the next step.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            phase <= ACTIVE;
        end else if (en) begin
            if (count >= LAST) begin
                count <= '0;
                phase <= ACTIVE;
            end else begin
                count <= count + COORD_W'(1);
                case (phase)
                    ACTIVE:  if (count == ACT_END)  phase <= FRONT;
                    FRONT:   if (count == FP_END)   phase <= SYNC;
                    SYNC:    if (count == SYNC_END) phase <= BACK;
                    default: phase <= BACK;
                endcase
            end
        end
    end

endmodule

// File: rtl/vga_timing.sv
// VGA raster generator: pixel divider, chained H/V axis counters and an aligned output register.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV    = 1,
    parameter int H_ACT_LEN  = H_ACTIVE,
    parameter int H_FP_LEN   = H_FP,
    parameter int H_SYNC_LEN = H_SYNC,
    parameter int H_BP_LEN   = H_BP,
    parameter int V_ACT_LEN  = V_ACTIVE,
    parameter int V_FP_LEN   = V_FP,
    parameter int V_SYNC_LEN = V_SYNC,
    parameter int V_BP_LEN   = V_BP
) (
    input  logic               clk,
    input  logic               reset,
    output logic [COORD_W-1:0] colPos,
    output logic [COORD_W-1:0] rowPos,
    output logic               on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start,
    output logic               line_start
);

    logic [1:0]         div;
    logic               tick;
    logic               first;
    logic [COORD_W-1:0] hcnt;
    logic [COORD_W-1:0] vcnt;
    vga_phase_t         h_phase;
    vga_phase_t         v_phase;
    logic               h_tc;
    logic               v_tc_unused;

    assign tick  = (div == 2'(CLK_DIV - 1));
    assign first = (div == 2'd0);

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            div <= 2'd0;
        end else begin
            div <= div + 2'd1;
        end
    end

    vga_axis_counter #(
        .ACT_LEN (H_ACT_LEN),
        .FP_LEN  (H_FP_LEN),
        .SYNC_LEN(H_SYNC_LEN),
        .BP_LEN  (H_BP_LEN)
    ) u_h (
        .clk  (clk),
        .reset(reset),
        .en   (tick),
        .count(hcnt),
        .phase(h_phase),
        .tc   (h_tc)
    );

    // The vertical axis steps once per line, on the last pixel tick of the line.
    vga_axis_counter #(
        .ACT_LEN (V_ACT_LEN),
        .FP_LEN  (V_FP_LEN),
        .SYNC_LEN(V_SYNC_LEN),
        .BP_LEN  (V_BP_LEN)
    ) u_v (
        .clk  (clk),
        .reset(reset),
        .en   (tick && h_tc),
        .count(vcnt),
        .phase(v_phase),
        .tc   (v_tc_unused)
    );

    // Every output comes from the same register stage so coordinates, syncs and strobes stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            colPos      <= '0;
            rowPos      <= '0;
            on          <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            colPos      <= hcnt;
            rowPos      <= vcnt;
            on          <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
            hsync       <= (h_phase != SYNC);
            vsync       <= (v_phase != SYNC);
            frame_start <= first && (hcnt == '0) && (vcnt == '0);
            line_start  <= first && (hcnt == '0);
        end
    end

endmodule
